// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and line constants.
// Used by both the TX and RX engines.
package uart_pkg;

  localparam int   DATA_W_DEF = 8;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Loadable bit-period down-counter; tick marks the last cycle of the current bit.
// A divisor of 0 behaves like 1 (one cycle per bit).
module uart_baud_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= (div == '0) ? '0 : div - DIV_W'(1);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - DIV_W'(1);
    end
  end

  assign tick = (cnt_q == '0);

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit serializer: start, LSB-first data, optional parity, 1/2 stop bits.
// All outputs are registered; status strobes feed the UART status register.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int DIV_W  = 16,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] din,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic              par_en,
  input  logic              par_odd,
  input  logic              stop2,
  output logic              tx,
  output logic              TXactive,
  output logic              TXdone,
  output logic              loadTXactive,
  output logic              loadTXdone
);

  localparam int              IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  uart_state_e       state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              stop_q, stop_d;
  logic              par_q, par_d;
  logic [DIV_W-1:0]  div_q;
  logic              par_en_q, stop2_q;
  logic              tx_q, tx_d;
  logic              active_q, active_d;
  logic              ld_active_q, ld_active_d;
  logic              done_q, done_d;
  logic              capture, load, tick;
  logic [DIV_W-1:0]  div_sel;

  // The frame's first bit period must use the divisor presented with start.
  assign div_sel = (state_q == IDLE) ? baud_div : div_q;

  uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .div  (div_sel),
    .tick (tick)
  );

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    stop_d      = stop_q;
    par_d       = par_q;
    tx_d        = tx_q;
    active_d    = active_q;
    ld_active_d = 1'b0;
    done_d      = 1'b0;
    capture     = 1'b0;
    load        = 1'b0;

    unique case (state_q)
      IDLE: begin
        tx_d = IDLE_LEVEL;
        if (start) begin
          capture     = 1'b1;
          load        = 1'b1;
          state_d     = START;
          tx_d        = 1'b0;
          active_d    = 1'b1;
          ld_active_d = 1'b1;
          shift_d     = din;
          par_d       = par_odd;
          idx_d       = '0;
          stop_d      = 1'b0;
        end
      end
      START: if (tick) begin
        load    = 1'b1;
        state_d = DATA;
        tx_d    = shift_q[0];
      end
      DATA: if (tick) begin
        load    = 1'b1;
        par_d   = par_q ^ shift_q[0];
        shift_d = shift_q >> 1;
        if (idx_q == LAST_IDX) begin
          state_d = par_en_q ? PARITY : STOP;
          tx_d    = par_en_q ? (par_q ^ shift_q[0]) : IDLE_LEVEL;
        end else begin
          idx_d = idx_q + IDX_W'(1);
          tx_d  = shift_q[1];
        end
      end
      PARITY: if (tick) begin
        load    = 1'b1;
        state_d = STOP;
        tx_d    = IDLE_LEVEL;
      end
      STOP: if (tick) begin
        if (stop2_q && !stop_q) begin
          load   = 1'b1;
          stop_d = 1'b1;
        end else begin
          state_d  = IDLE;
          active_d = 1'b0;
          done_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      idx_q       <= '0;
      stop_q      <= 1'b0;
      par_q       <= 1'b0;
      div_q       <= '0;
      par_en_q    <= 1'b0;
      stop2_q     <= 1'b0;
      tx_q        <= IDLE_LEVEL;
      active_q    <= 1'b0;
      ld_active_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      stop_q      <= stop_d;
      par_q       <= par_d;
      tx_q        <= tx_d;
      active_q    <= active_d;
      ld_active_q <= ld_active_d;
      done_q      <= done_d;
      if (capture) begin
        div_q    <= baud_div;
        par_en_q <= par_en;
        stop2_q  <= stop2;
      end
    end
  end

  assign tx           = tx_q;
  assign TXactive     = active_q;
  assign TXdone       = done_q;
  assign loadTXactive = ld_active_q;
  assign loadTXdone   = done_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine: expected line/status waveforms are built
// per cycle from the frame format and compared on the falling clock edge.
module tb_uart_tx_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  din = 8'h00;
  logic [15:0] baud_div = 16'd1;
  logic        par_en = 1'b0;
  logic        par_odd = 1'b0;
  logic        stop2 = 1'b0;
  logic        tx, TXactive, TXdone, loadTXactive, loadTXdone;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic tx;
    logic act;
    logic lda;
    logic done;
    logic ldd;
  } obs_t;

  obs_t exp_q[$];

  uart_tx_engine #(.DIV_W(16), .DATA_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .din          (din),
    .baud_div     (baud_div),
    .par_en       (par_en),
    .par_odd      (par_odd),
    .stop2        (stop2),
    .tx           (tx),
    .TXactive     (TXactive),
    .TXdone       (TXdone),
    .loadTXactive (loadTXactive),
    .loadTXdone   (loadTXdone)
  );

  always #5 clk = ~clk;

  function automatic obs_t observe();
    obs_t o;
    o = '{tx: tx, act: TXactive, lda: loadTXactive, done: TXdone, ldd: loadTXdone};
    return o;
  endfunction

  // Reference: list the frame's bits from the format rules, stretch each to its period,
  // then append the single TXdone cycle (line high, TXactive low).
  task automatic push_frame(input logic [7:0] d, input int div, input bit pe, input bit po,
                            input bit s2);
    int per;
    bit bits[$];
    per = (div == 0) ? 1 : div;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pe) bits.push_back(bit'($countones(d) % 2) ^ po);
    bits.push_back(1'b1);
    if (s2) bits.push_back(1'b1);
    for (int b = 0; b < bits.size(); b++)
      for (int c = 0; c < per; c++)
        exp_q.push_back('{tx: bits[b], act: 1'b1, lda: (b == 0 && c == 0), done: 1'b0, ldd: 1'b0});
    exp_q.push_back('{tx: 1'b1, act: 1'b0, lda: 1'b0, done: 1'b1, ldd: 1'b1});
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back('{tx: 1'b1, act: 1'b0, lda: 1'b0, done: 1'b0, ldd: 1'b0});
  endtask

  // Compares up to max_n queued cycles; optionally raises a busy-time start (din=FF)
  // at pulse_idx and drops start at drop_idx.
  task automatic check_stream(input string name, input int max_n, input int pulse_idx,
                              input int drop_idx);
    int   n;
    obs_t e, got;
    n = 0;
    while (exp_q.size() > 0 && n < max_n) begin
      @(negedge clk);
      e   = exp_q.pop_front();
      got = observe();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL %s cycle %0d: tx/act/ldact/done/lddone got=%b expected=%b",
                 name, n, got, e);
      end
      if (n == pulse_idx) begin
        start = 1'b1;
        din   = 8'hFF;
      end
      if (n == drop_idx) start = 1'b0;
      n++;
    end
    exp_q.delete();
  endtask

  // Presents a frame request for one edge, then scrambles the inputs mid-frame.
  task automatic send(input logic [7:0] d, input int div, input bit pe, input bit po,
                      input bit s2);
    @(negedge clk);
    din      = d;
    baud_div = 16'(div);
    par_en   = pe;
    par_odd  = po;
    stop2    = s2;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    din      = 8'($urandom);
    baud_div = 16'($urandom_range(0, 7));
    par_en   = 1'($urandom);
    par_odd  = 1'($urandom);
    stop2    = 1'($urandom);
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;
    repeat (3) @(posedge clk);
    push_idle(1);
    check_stream("reset_state", 1, -1, -1);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    push_idle(2);
    check_stream("after_reset_idle", 2, -1, -1);
  endtask

  task automatic test_basic();
    push_frame(8'hA5, 4, 1'b0, 1'b0, 1'b0);
    push_idle(3);
    send(8'hA5, 4, 1'b0, 1'b0, 1'b0);
    check_stream("basic_a5_div4", 1000, -1, -1);
  endtask

  task automatic test_parity();
    push_frame(8'hA5, 4, 1'b1, 1'b0, 1'b0);
    push_idle(2);
    send(8'hA5, 4, 1'b1, 1'b0, 1'b0);
    check_stream("parity_even", 1000, -1, -1);
    push_frame(8'hA5, 4, 1'b1, 1'b1, 1'b0);
    push_idle(2);
    send(8'hA5, 4, 1'b1, 1'b1, 1'b0);
    check_stream("parity_odd", 1000, -1, -1);
  endtask

  task automatic test_div0_stop2();
    push_frame(8'h01, 0, 1'b0, 1'b0, 1'b1);
    push_idle(2);
    send(8'h01, 0, 1'b0, 1'b0, 1'b1);
    check_stream("div0_stop2", 1000, -1, -1);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) push_frame(8'h3C, 2, 1'b0, 1'b0, 1'b0);
    push_idle(3);
    @(negedge clk);
    din      = 8'h3C;
    baud_div = 16'd2;
    par_en   = 1'b0;
    par_odd  = 1'b0;
    stop2    = 1'b0;
    start    = 1'b1;
    @(posedge clk);
    #1;
    // Each frame is 20 active cycles plus its TXdone cycle; drop start inside frame three.
    check_stream("back_to_back", 1000, -1, 45);
  endtask

  task automatic test_busy_start();
    push_frame(8'h00, 2, 1'b0, 1'b0, 1'b0);
    push_idle(4);
    send(8'h00, 2, 1'b0, 1'b0, 1'b0);
    check_stream("busy_start_mid", 1000, 5, 6);
    push_frame(8'h00, 2, 1'b0, 1'b0, 1'b0);
    push_idle(4);
    send(8'h00, 2, 1'b0, 1'b0, 1'b0);
    check_stream("busy_start_last_stop", 1000, 19, 20);
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    d = 8'($urandom);
    push_frame(d, 4, 1'b0, 1'b0, 1'b0);
    send(d, 4, 1'b0, 1'b0, 1'b0);
    // Cycles 16..19 of the frame carry data bit 3.
    check_stream("pre_abort", 18, -1, -1);
    rst = 1'b1;
    push_idle(1);
    check_stream("abort_edge", 1, -1, -1);
    rst = 1'b0;
    push_idle(44);
    check_stream("abort_no_done", 44, -1, -1);
    d = 8'($urandom);
    push_frame(d, 4, 1'b1, 1'b1, 1'b1);
    push_idle(2);
    send(d, 4, 1'b1, 1'b1, 1'b1);
    check_stream("after_abort_frame", 1000, -1, -1);
  endtask

  task automatic test_random();
    logic [7:0] d;
    int         div;
    bit         pe, po, s2;
    for (int k = 0; k < 12; k++) begin
      d   = 8'($urandom);
      div = $urandom_range(0, 5);
      pe  = 1'($urandom);
      po  = 1'($urandom);
      s2  = 1'($urandom);
      push_frame(d, div, pe, po, s2);
      push_idle(1);
      send(d, div, pe, po, s2);
      check_stream($sformatf("random_%0d", k), 1000, -1, -1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_div0_stop2();
    test_back_to_back();
    test_busy_start();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
